// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-requester write-port arbiter for regFile (optional round-robin: REGFILE_ARB_RR_EN)
module regfile_wr_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic [AW-1:0] Wadd,
  output logic [DW-1:0] Wdata,
  output logic          isWreg,
  output logic          busy,
  output logic [CW-1:0] commit_cnt
);

  logic          occ0, occ1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          last;
  logic          grant0, grant1;
  logic          tie_to0;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;
  logic          acc0, acc1;

  // Tie-break selection: round-robin follows the last winner, fixed priority always favours requester 0
  always_comb begin
    tie_to0 = 1'b1;
`ifdef REGFILE_ARB_RR_EN
    tie_to0 = last;
`else
    // last keeps updating for visibility but never changes the outcome here
    tie_to0 = last | 1'b1;
`endif
  end

  // Grant one occupied slot and mux its contents toward the write port
  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    gnt_addr = addr0;
    gnt_data = data0;
    if (occ0 && occ1) begin
      grant0 = tie_to0;
      grant1 = !tie_to0;
    end else begin
      grant0 = occ0;
      grant1 = occ1;
    end
    if (grant1) begin
      gnt_addr = addr1;
      gnt_data = data1;
    end
  end

  assign req0_ready = rstn && (!occ0 || grant0);
  assign req1_ready = rstn && (!occ1 || grant1);
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign busy       = occ0 || occ1 || isWreg;

  // Requester 0 holding slot: reload on accept (even while draining), clear when issued
  always_ff @(posedge clk) begin
    if (!rstn) begin
      occ0  <= 1'b0;
      addr0 <= '0;
      data0 <= '0;
    end else if (acc0) begin
      occ0  <= 1'b1;
      addr0 <= req0_addr;
      data0 <= req0_data;
    end else if (grant0) begin
      occ0  <= 1'b0;
    end
  end

  // Requester 1 holding slot: same behaviour as requester 0
  always_ff @(posedge clk) begin
    if (!rstn) begin
      occ1  <= 1'b0;
      addr1 <= '0;
      data1 <= '0;
    end else if (acc1) begin
      occ1  <= 1'b1;
      addr1 <= req1_addr;
      data1 <= req1_data;
    end else if (grant1) begin
      occ1  <= 1'b0;
    end
  end

  // Registered write port, x0 filter, winner pointer and commit counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      Wadd       <= '0;
      Wdata      <= '0;
      isWreg     <= 1'b0;
      last       <= 1'b1;
      commit_cnt <= '0;
    end else if (grant0 || grant1) begin
      Wadd   <= gnt_addr;
      Wdata  <= gnt_data;
      isWreg <= (gnt_addr != '0);
      last   <= grant1;
      if (gnt_addr != '0) begin
        commit_cnt <= commit_cnt + CW'(1);
      end
    end else begin
      isWreg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [4:0]  Wadd;
  logic [31:0] Wdata;
  logic        isWreg;
  logic        busy;
  logic [15:0] commit_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [0:31];
  logic [15:0] tb_writes = '0;

  regfile_wr_arbiter #(.AW(5), .DW(32), .CW(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .Wadd       (Wadd),
    .Wdata      (Wdata),
    .isWreg     (isWreg),
    .busy       (busy),
    .commit_cnt (commit_cnt)
  );

  always #5 clk = ~clk;

  // regFile stand-in and independent write counter
  always @(posedge clk) begin
    if (isWreg) begin
      rf[Wadd]  <= Wdata;
      tb_writes <= tb_writes + 16'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        r0, r1;
    int          n0, n1;
    int          cnt_base;
    int          rem;
    int          guard;
    logic [15:0] w_snap;

    for (int k = 0; k < 32; k++) rf[k] = '0;

    // reset with a pending request
    rstn = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h2;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'h0;
    repeat (5) tick();
    chk("rst_iswreg", isWreg, 1'b0);
    chk("rst_wadd", Wadd, 5'd0);
    chk("rst_wdata", Wdata, 32'h0);
    chk("rst_cnt", commit_cnt, 16'd0);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rstn = 1'b1;
    #1;
    chk("rel_ready0", req0_ready, 1'b1);
    chk("rel_ready1", req1_ready, 1'b1);

    // single write x1 <= 2
    tick();
    req0_valid = 1'b0;
    chk("single_e0_iswreg", isWreg, 1'b0);
    chk("single_e0_busy", busy, 1'b1);
    tick();
    chk("single_iswreg", isWreg, 1'b1);
    chk("single_wadd", Wadd, 5'd1);
    chk("single_wdata", Wdata, 32'h2);
    chk("single_cnt", commit_cnt, 16'd1);
    tick();
    chk("single_rf1", rf[1], 32'h2);
    chk("single_iswreg_off", isWreg, 1'b0);
    chk("single_busy_off", busy, 1'b0);

    // x0 filter on requester 1
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1;
    tick();
    req1_valid = 1'b0;
    chk("x0_ready1", req1_ready, 1'b1);
    chk("x0_iswreg_a", isWreg, 1'b0);
    tick();
    chk("x0_iswreg_b", isWreg, 1'b0);
    chk("x0_cnt", commit_cnt, 16'd1);
    chk("x0_rf0", rf[0], 32'h0);
    chk("x0_busy", busy, 1'b0);

    // contention: both requesters valid every cycle
    n0 = 0; n1 = 0;
    req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'hA0;
    req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'hB0;
    for (int i = 0; i <= 8; i++) begin
      r0 = req0_ready;
      r1 = req1_ready;
      tick();
      if (r0) begin n0++; req0_data = 32'hA0 + 32'(n0); end
      if (r1) begin n1++; req1_data = 32'hB0 + 32'(n1); end
      if (i == 0) begin
        chk("cont_ready0_e0", r0, 1'b1);
        chk("cont_ready1_e0", r1, 1'b1);
      end else begin
        chk($sformatf("cont_iswreg_%0d", i), isWreg, 1'b1);
`ifdef REGFILE_ARB_RR_EN
        chk($sformatf("cont_ready0_%0d", i), r0, (i % 2) == 1);
        chk($sformatf("cont_ready1_%0d", i), r1, (i % 2) == 0);
        if (i % 2 == 1) begin
          chk($sformatf("cont_wadd_%0d", i), Wadd, 5'd2);
          chk($sformatf("cont_wdata_%0d", i), Wdata, 32'hA0 + 32'((i - 1) / 2));
        end else begin
          chk($sformatf("cont_wadd_%0d", i), Wadd, 5'd3);
          chk($sformatf("cont_wdata_%0d", i), Wdata, 32'hB0 + 32'(i / 2 - 1));
        end
`else
        chk($sformatf("cont_ready0_%0d", i), r0, 1'b1);
        chk($sformatf("cont_ready1_%0d", i), r1, 1'b0);
        chk($sformatf("cont_wadd_%0d", i), Wadd, 5'd2);
        chk($sformatf("cont_wdata_%0d", i), Wdata, 32'hA0 + 32'(i - 1));
`endif
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    guard = 0;
    while (busy && guard < 10) begin
      tick();
      guard++;
    end
    chk("cont_drain_busy", busy, 1'b0);
    chk("cont_cnt_model", commit_cnt, tb_writes);

    // back-to-back stream x4..x7
    cnt_base = int'(commit_cnt);
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h10;
    for (int i = 0; i <= 4; i++) begin
      tick();
      if (i < 3) begin
        req0_addr = 5'd5 + 5'(i);
        req0_data = 32'h11 + 32'(i);
      end
      if (i == 3) req0_valid = 1'b0;
      if (i >= 1) begin
        chk($sformatf("b2b_iswreg_%0d", i), isWreg, 1'b1);
        chk($sformatf("b2b_wadd_%0d", i), Wadd, 5'd4 + 5'(i - 1));
        chk($sformatf("b2b_wdata_%0d", i), Wdata, 32'h10 + 32'(i - 1));
      end
    end
    tick();
    chk("b2b_iswreg_end", isWreg, 1'b0);
    chk("b2b_cnt", commit_cnt, 16'(cnt_base + 4));
    chk("b2b_rf7", rf[7], 32'h13);

    // stream until the commit counter wraps
    rem = 65536 - int'(tb_writes);
    req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 32'h55;
    repeat (rem) tick();
    req0_valid = 1'b0;
    tick();
    tick();
    chk("wrap_cnt", commit_cnt, 16'd0);
    chk("wrap_rf8", rf[8], 32'h55);

    // reset while both slots occupied
    req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 32'h99;
    req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h100;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("mid_busy_pre", busy, 1'b1);
    rstn = 1'b0;
    w_snap = tb_writes;
    tick();
    chk("mid_iswreg", isWreg, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_ready0", req0_ready, 1'b0);
    rstn = 1'b1;
    repeat (3) tick();
    chk("mid_no_writes", tb_writes, w_snap);
    chk("mid_rf9", rf[9], 32'h0);
    chk("mid_rf10", rf[10], 32'h0);
    chk("mid_busy_after", busy, 1'b0);
    chk("mid_cnt", commit_cnt, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the register file's single write port between two write requesters: requester 0 is core writeback and requester 1 is the debug/loader path. Each requester has a one-entry holding slot behind a valid/ready handshake. The arbiter grants one occupied slot per cycle and drives registered `Wadd`/`Wdata`/`isWreg` into `regFile`. It also filters writes to x0 and keeps a committed-write count for debug visibility.

## Interface
- `AW`, 5, register address width
- `DW`, 32, data width
- `CW`, 16, commit counter width
- `clk`  in  1  system clock; all state updates on rising edge
- `rstn`  in  1  synchronous active-low reset, sampled on rising edge of `clk`
- `req0_valid`  in  1  requester 0 has a write
- `req0_addr`  in  AW  requester 0 destination register
- `req0_data`  in  DW  requester 0 write data
- `req0_ready`  out  1  requester 0 slot can accept
- `req1_valid` / `req1_addr` / `req1_data` / `req1_ready`  same as requester 0, for requester 1
- `Wadd`  out  AW  to `regFile.Wadd`, registered
- `Wdata`  out  DW  to `regFile.Wdata`, registered
- `isWreg`  out  1  to `regFile.isWreg`, registered
- `busy`  out  1  any slot occupied or `isWreg` high
- `commit_cnt`  out  CW  number of writes issued with `isWreg`=1

## Operation
- **Per-requester slot:** `occ_i` flag plus addr/data registers.
  - `reqI_ready` = `!occ_i || grant_i`, forced to 0 while `rstn`=0.
  - Accept on a rising edge with `reqI_valid && reqI_ready`: the slot loads addr/data and `occ_i`=1.
  - Data and addr must stay stable while `valid` is high and `ready` is low.
- **Grant (combinational, from `occ` and pointer `last`):**
  - Only one slot occupied: that slot is granted.
  - Both occupied: grant `!last`. With `REGFILE_ARB_RR_EN` undefined, requester 0 always wins.
  - Neither occupied: no grant.
- **On a grant edge:**
  - `Wadd`/`Wdata` load from the granted slot.
  - `isWreg` = 1 if slot addr != 0; otherwise 0 (x0 write is consumed and discarded).
  - The slot clears, unless the same requester is accepted on that edge; it then reloads with the new entry (back-to-back, no bubble).
  - `last` = granted index.
  - `commit_cnt` += 1 only when `isWreg` is loaded as 1.
- **No grant:** `isWreg` loads 0; `Wadd`/`Wdata` hold their previous value.
- **Arithmetic:**
  - `commit_cnt` wraps modulo 2^CW (0xFFFF -> 0x0000) with no saturation or flag.
  - Addresses pass through unmodified, with no range check beyond the x0 filter.
- **Ordering:** per requester, writes issue in acceptance order. Between requesters, order is set by the grant policy only.
- **Simultaneous accept on both requesters with both slots empty:** both load. Requester 0 issues first if `last`=1 (or RR disabled), otherwise requester 1 issues first.

## Timing
- **Reset** (edge with `rstn`=0):
  - `occ0`=`occ1`=0
  - `last`=1, so requester 0 wins the first tie
  - `Wadd`=0, `Wdata`=0, `isWreg`=0, `commit_cnt`=0, `busy`=0
  - `reqI_ready`=0 while reset is held, and 1 in the first cycle after release
- **Reset mid-operation:** pending slot contents and any in-flight `isWreg` are discarded. No write reaches `regFile` after the reset edge.
- **Latency:** accept at edge E0 -> grant at E1 (when uncontested) -> `isWreg`/`Wadd`/`Wdata` valid during cycle E1..E2 -> `regFile` commits at E2. Contested writes incur one additional cycle per losing round.
- **Throughput:** one write per cycle sustained. Each requester sustains one per cycle when alone and one per two cycles under contention with RR.
- **`isWreg`:** high for exactly one cycle per issued write.
- **`busy`:** combinational OR of `occ0`, `occ1` and `isWreg`.

## Configuration
- **`REGFILE_ARB_RR_EN` defined:** round-robin on contention using `last`. A requester waits at most one grant.
- **`REGFILE_ARB_RR_EN` undefined:** fixed priority to requester 0.
  - `last` still updates but is ignored for tie-breaking.
  - Requester 1 can starve while requester 0 streams.

## Test plan
- **Reset:** hold `rstn`=0 for 5 cycles with `req0_valid`=1 -> `isWreg`=0, `Wadd`=0, `Wdata`=0, `commit_cnt`=0, `req0_ready`=0; after release, `req0_ready`=1.
- **Single write:** `req0` writes addr 1, data 0x2, accepted at E0 -> `isWreg`=1, `Wadd`=1, `Wdata`=0x2 in cycle E1..E2; `regFile` read of x1 returns 0x2; `commit_cnt`=1.
- **x0 filter:** `req1` writes addr 0, data 0x1 -> `req1_ready` returns to 1 and `isWreg` stays 0; `commit_cnt` is unchanged; `regFile` x0 reads 0.
- **Contention with RR on:** both requesters valid every cycle (req0: addr 2 data 0xA…, req1: addr 3 data 0xB…) -> grants alternate 0,1,0,1 starting with requester 0; each `ready` is high every other cycle. With RR off, only requester 0 issues.
- **Back-to-back:** `req0` streams 4 writes to addr 4..7 with data 0x10..0x13 -> `isWreg` is high for 4 consecutive cycles with no bubble; `commit_cnt`=4.
- **Counter wrap and mid-operation reset:** preload `commit_cnt` via 65536 writes -> `commit_cnt` wraps to 0. Then, with both slots occupied, assert `rstn`=0 for 1 cycle -> no further `isWreg`; `busy`=0 on the next cycle.
